stim_pwm_gen: RTL and testbench
===============================

Name: stim_pwm_gen

Overview:
- Multi-channel, run-time programmable PWM stimulus source for emulator testbenches; the parametrised successor to a fixed-duty, fixed-frequency square-wave source selecting between two constant reals.
- Each channel emits a digital PWM bit plus a signed fixed-point value (v_hi or v_lo) that feeds analog models such as filters.
- Adds per-channel period/duty/phase/levels, glitch-free shadowed updates at period wrap, and a one-shot mode.

Parameters:
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 16, period/high/phase counter width
- VAL_W, 16, signed fixed-point output width (same scaling as the downstream real signal)
- CFG_W, 32, config data width; must be >= max(CNT_W, VAL_W)

Ports:
- emu_clk  in  1  emulator clock
- emu_rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&&ready
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_addr  in  3  register select
- cfg_data  in  CFG_W  write data (LSB-aligned)
- dig  out  N_CH  PWM bit per channel
- val  out  N_CH*VAL_W  signed level per channel; channel k in bits [k*VAL_W +: VAL_W]
- wrap  out  N_CH  one-cycle pulse per channel when its counter restarts at 0

Behaviour:
- Reset: all counters, pending and active registers 0; en=0; dig=0, val=0, wrap=0, cfg_ready=0 while emu_rst is high, then 1.
- cfg_ready=1 whenever not in reset: one write per cycle, no back-pressure. cfg_ch >= N_CH, or cfg_addr 6..7: write is accepted and ignored.
- Address map:
  - 0 PERIOD P
  - 1 HIGH H
  - 2 PHASE PH
  - 3 V_HI
  - 4 V_LO
  - 5 CTRL: bit0 en, bit1 oneshot
- Addresses 0-4 write pending (shadow) registers. V_HI/V_LO take bits [VAL_W-1:0] as two's complement.
- CTRL is written immediately, not shadowed.
- Commit (pending -> active) occurs:
  - in the cycle the counter wraps (cnt==P-1);
  - every cycle while en=0;
  - in the cycle en rises.
- A write landing in the same cycle as a wrap commit is NOT included in that commit; it takes effect at the next wrap.
- Counter, en=1:
  - cnt <= (cnt==P-1) ? 0 : cnt+1.
  - On the en rising edge, cnt <= (PH < P) ? PH : 0, using the newly committed P and PH.
- Counter, en=0: cnt held at 0.
- Output, registered with latency 1 from counter state:
  - dig <= en && (cnt < H_active)
  - val <= dig_next ? V_HI_active : V_LO_active
  - wrap <= en && cnt==P-1
  - With en=0: dig=0, val=V_LO_active.
- Boundaries:
  - P==0: channel behaves as disabled (dig=0, val=V_LO), en bit retained.
  - P==1: cnt stays at 0; wrap every cycle.
  - H==0: dig always 0.
  - H >= P: dig always 1.
- Oneshot=1: the channel runs one full period from its start point, then hardware clears en in the cycle of the first wrap. wrap still pulses once; dig returns to 0 on the following cycle.
- Writing CTRL en=1 while already enabled: no counter reload. en=0: stops next cycle.
- emu_rst mid-operation: everything returns to reset values next edge, including pending registers.
- Channels are fully independent; there is no shared counter.

Decomposition:
- Package stim_pwm_pkg:
  - address localparams/enum (ADDR_PERIOD..ADDR_CTRL)
  - CTRL bit indices (CTRL_EN=0, CTRL_ONESHOT=1)
- Sub-module stim_pwm_ch: one channel's pending/active registers, counter, commit and oneshot logic.
- Top level: decodes cfg_ch, drives per-channel write strobes, instantiates stim_pwm_ch N_CH times in a generate loop, concatenates outputs.

Test Plan:
- Reset, then program ch0 P=1000, H=500, V_HI=+1.0 (fixed-point), V_LO=-1.0, en=1:
  - dig0 50% duty, 1000-cycle period;
  - val0 toggles between the two codes;
  - wrap0 pulses every 1000 cycles.
- Two channels, both P=8, H=4, ch1 PH=2, enabled in the same cycle: dig1 leads dig0 by 2 cycles; no other channel toggles.
- ch0 running P=10, H=3; write H=7 at mid-period, and separately in the exact wrap cycle:
  - mid-period write: old duty until wrap, new duty from the next period;
  - wrap-cycle write: applied one period later.
- Boundary values:
  - H=0 gives dig=0 constantly;
  - H=12 with P=10 gives dig=1 constantly;
  - P=0 gives dig=0 and val=V_LO;
  - P=1 gives wrap=1 every cycle.
- Oneshot with P=6, H=2:
  - exactly one dig pulse of 2 cycles and one wrap pulse;
  - CTRL.en reads back 0 afterwards; dig stays 0.
- Assert emu_rst for one cycle mid-period: next cycle dig=0, val=0, wrap=0, cfg_ready=0; re-enabling requires full reprogramming.

Source files
------------

// File: rtl/stim_pwm_pkg.sv
// Package: stim_pwm_pkg
// Shared constants for the PWM stimulus generator.
//   cfg_addr_e    : register select codes on the config bus
//   CTRL_EN       : CTRL bit that enables a channel
//   CTRL_ONESHOT  : CTRL bit that makes the channel stop after one period
//   ch_idx_w()    : width of the channel-select field (at least 1 bit)
package stim_pwm_pkg;

    typedef enum logic [2:0] {
        ADDR_PERIOD = 3'd0,
        ADDR_HIGH   = 3'd1,
        ADDR_PHASE  = 3'd2,
        ADDR_V_HI   = 3'd3,
        ADDR_V_LO   = 3'd4,
        ADDR_CTRL   = 3'd5
    } cfg_addr_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stim_pwm_gen_if.sv
// Interface: stim_pwm_gen_if
// Config write bus for the PWM stimulus generator. One write per cycle,
// accepted when cfg_valid && cfg_ready.
//   cfg_valid : write request
//   cfg_ready : generator accepts writes (low during and just after reset)
//   cfg_ch    : target channel
//   cfg_addr  : register select (see cfg_addr_e)
//   cfg_data  : LSB-aligned write data
interface stim_pwm_gen_if #(
    parameter int N_CH  = 4,
    parameter int CFG_W = 32
);
    import stim_pwm_pkg::*;

    localparam int CH_W = ch_idx_w(N_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [2:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_data;

    modport master (
        output cfg_valid, cfg_ch, cfg_addr, cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_addr, cfg_data,
        output cfg_ready
    );

endinterface

// File: rtl/stim_pwm_ch.sv
// Module: stim_pwm_ch
// One PWM channel: pending (shadow) and active period/high/phase/level
// registers, free-running period counter, commit and one-shot logic.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : accepted config write addressed to this channel
//   wr_addr   : register select
//   wr_data   : write data
//   dig       : PWM bit (registered)
//   val       : signed output level, V_HI while dig=1 else V_LO (registered)
//   wrap      : one-cycle pulse after the counter's last count of a period
module stim_pwm_ch
    import stim_pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int VAL_W = 16,
    parameter int CFG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [CFG_W-1:0] wr_data,
    output logic             dig,
    output logic [VAL_W-1:0] val,
    output logic             wrap
);

    logic [CNT_W-1:0] pend_p, pend_h, pend_ph;
    logic [VAL_W-1:0] pend_vhi, pend_vlo;
    logic [CNT_W-1:0] act_p, act_h;
    logic [VAL_W-1:0] act_vhi, act_vlo;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] start_cnt;
    logic             en, oneshot;
    logic             ctrl_wr, rise, run, at_end, commit, dig_next;
    logic             unused_data;

    assign unused_data = ^wr_data;

    assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
    assign rise     = ctrl_wr && wr_data[CTRL_EN] && !en;
    // A zero period makes an enabled channel look disabled.
    assign run      = en && (act_p != '0);
    assign at_end   = run && (cnt == act_p - CNT_W'(1));
    // Commit reads the pending registers before this cycle's write lands, so a
    // write in a wrap cycle waits for the following wrap. The rising-enable
    // cycle is covered because en is still 0 there.
    assign commit   = !run || at_end;
    // Start point uses the values being committed on this edge.
    assign start_cnt = (pend_ph < pend_p) ? pend_ph : '0;
    assign dig_next = run && (cnt < act_h);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p   <= '0;
            pend_h   <= '0;
            pend_ph  <= '0;
            pend_vhi <= '0;
            pend_vlo <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_PERIOD: pend_p   <= wr_data[CNT_W-1:0];
                ADDR_HIGH:   pend_h   <= wr_data[CNT_W-1:0];
                ADDR_PHASE:  pend_ph  <= wr_data[CNT_W-1:0];
                ADDR_V_HI:   pend_vhi <= wr_data[VAL_W-1:0];
                ADDR_V_LO:   pend_vlo <= wr_data[VAL_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_p   <= '0;
            act_h   <= '0;
            act_vhi <= '0;
            act_vlo <= '0;
        end else if (commit) begin
            act_p   <= pend_p;
            act_h   <= pend_h;
            act_vhi <= pend_vhi;
            act_vlo <= pend_vlo;
        end
    end

    // A CTRL write wins over the one-shot self-clear landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
        end else if (ctrl_wr) begin
            en      <= wr_data[CTRL_EN];
            oneshot <= wr_data[CTRL_ONESHOT];
        end else if (at_end && oneshot) begin
            en      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= start_cnt;
        end else if (!run || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig  <= 1'b0;
            val  <= '0;
            wrap <= 1'b0;
        end else begin
            dig  <= dig_next;
            val  <= dig_next ? act_vhi : act_vlo;
            wrap <= at_end;
        end
    end

endmodule

// File: rtl/stim_pwm_gen.sv
// Module: stim_pwm_gen
// Multi-channel run-time programmable PWM stimulus source. Each channel
// drives a PWM bit and a signed fixed-point level for downstream analog models.
//   emu_clk : emulator clock
//   emu_rst : synchronous active-high reset
//   cfg     : config write bus (slave side)
//   dig     : PWM bit per channel
//   val     : signed level per channel, channel k at [k*VAL_W +: VAL_W]
//   wrap    : per-channel period-restart pulse
module stim_pwm_gen
    import stim_pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int VAL_W = 16,
    parameter int CFG_W = 32
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    stim_pwm_gen_if.slave         cfg,
    output logic [N_CH-1:0]       dig,
    output logic [N_CH*VAL_W-1:0] val,
    output logic [N_CH-1:0]       wrap
);

    localparam int CH_W = ch_idx_w(N_CH);

    logic            ready_q;
    logic [N_CH-1:0] wr_sel;

    // Registered so ready stays low for the cycle following a reset pulse.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign cfg.cfg_ready = ready_q;

    // Out-of-range channel numbers match no strobe and are dropped.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign wr_sel[k] = cfg.cfg_valid && ready_q && (cfg.cfg_ch == CH_W'(k));

        stim_pwm_ch #(
            .CNT_W (CNT_W),
            .VAL_W (VAL_W),
            .CFG_W (CFG_W)
        ) u_ch (
            .clk     (emu_clk),
            .rst     (emu_rst),
            .wr_en   (wr_sel[k]),
            .wr_addr (cfg.cfg_addr),
            .wr_data (cfg.cfg_data),
            .dig     (dig[k]),
            .val     (val[k*VAL_W +: VAL_W]),
            .wrap    (wrap[k])
        );
    end

endmodule

// File: tb/tb_stim_pwm_gen.sv
// Testbench for stim_pwm_gen: table of steady-state channel settings plus
// hand-written sequences for phase, shadow timing, one-shot and reset.
module tb_stim_pwm_gen;
    import stim_pwm_pkg::*;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;
    localparam int VAL_W = 16;
    localparam int CFG_W = 32;
    localparam logic [VAL_W-1:0] V_POS = 16'h4000;  // +1.0 in Q2.14
    localparam logic [VAL_W-1:0] V_NEG = 16'hC000;  // -1.0 in Q2.14

    logic                  emu_clk = 1'b0;
    logic                  emu_rst;
    logic [N_CH-1:0]       dig;
    logic [N_CH*VAL_W-1:0] val;
    logic [N_CH-1:0]       wrap;

    stim_pwm_gen_if #(.N_CH(N_CH), .CFG_W(CFG_W)) cfg_if ();

    stim_pwm_gen #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .VAL_W (VAL_W),
        .CFG_W (CFG_W)
    ) dut (
        .emu_clk (emu_clk),
        .emu_rst (emu_rst),
        .cfg     (cfg_if),
        .dig     (dig),
        .val     (val),
        .wrap    (wrap)
    );

    always #5 emu_clk = ~emu_clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; the write is captured on the next posedge.
    task automatic cfg_wr(input int ch, input logic [2:0] addr, input logic [31:0] data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch[1:0];
        cfg_if.cfg_addr  = addr;
        cfg_if.cfg_data  = data;
        @(negedge emu_clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic setup(input int ch, input int p, input int h, input int ph);
        cfg_wr(ch, ADDR_CTRL, 32'd0);
        cfg_wr(ch, ADDR_PERIOD, p);
        cfg_wr(ch, ADDR_HIGH, h);
        cfg_wr(ch, ADDR_PHASE, ph);
        cfg_wr(ch, ADDR_V_HI, {16'h0, V_POS});
        cfg_wr(ch, ADDR_V_LO, {16'h0, V_NEG});
    endtask

    // Samples dig0 / wrap0 at the current negedge and the next n-1 ones;
    // first sample ends up in the MSB of the used range.
    task automatic sample0(input int n, output logic [63:0] d, output logic [63:0] w);
        d = '0;
        w = '0;
        for (int i = 0; i < n; i++) begin
            d = {d[62:0], dig[0]};
            w = {w[62:0], wrap[0]};
            @(negedge emu_clk);
        end
    endtask

    typedef struct {
        int p;
        int h;
        int ph;
        int win;
        int exp_high;
        int exp_wrap;
        int exp_first;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, w;
        logic [15:0] d0, d1;
        int highs, wraps, first, valbad, sidebad;

        vecs[0] = '{1000, 500, 0, 2000, 1000, 2, 1};
        vecs[1] = '{10, 3, 0, 20, 6, 2, 1};
        vecs[2] = '{10, 0, 0, 20, 0, 2, 0};
        vecs[3] = '{10, 12, 0, 20, 20, 2, 1};
        vecs[4] = '{0, 5, 0, 20, 0, 0, 0};
        vecs[5] = '{1, 1, 0, 20, 20, 20, 1};
        vecs[6] = '{1, 0, 0, 20, 0, 20, 0};
        vecs[7] = '{8, 4, 6, 20, 10, 3, 0};
        vecs[8] = '{8, 4, 9, 20, 12, 2, 1};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_data  = '0;
        emu_rst = 1'b1;
        repeat (3) @(negedge emu_clk);
        chk("reset_dig", 64'(dig), 64'd0);
        chk("reset_val", 64'(val), 64'd0);
        chk("reset_wrap", 64'(wrap), 64'd0);
        chk("reset_ready", 64'(cfg_if.cfg_ready), 64'd0);
        emu_rst = 1'b0;
        @(negedge emu_clk);
        chk("ready_after_reset", 64'(cfg_if.cfg_ready), 64'd1);

        foreach (vecs[v]) begin
            setup(0, vecs[v].p, vecs[v].h, vecs[v].ph);
            cfg_wr(0, ADDR_CTRL, 32'd1);
            @(negedge emu_clk);
            highs = 0; wraps = 0; first = 0; valbad = 0; sidebad = 0;
            for (int i = 0; i < vecs[v].win; i++) begin
                if (i == 0) first = int'(dig[0]);
                highs += int'(dig[0]);
                wraps += int'(wrap[0]);
                if (val[VAL_W-1:0] !== (dig[0] ? V_POS : V_NEG)) valbad++;
                if (dig[N_CH-1:1] != '0 || wrap[N_CH-1:1] != '0) sidebad++;
                @(negedge emu_clk);
            end
            chk($sformatf("vec%0d_high", v), 64'(highs), 64'(vecs[v].exp_high));
            chk($sformatf("vec%0d_wrap", v), 64'(wraps), 64'(vecs[v].exp_wrap));
            chk($sformatf("vec%0d_first", v), 64'(first), 64'(vecs[v].exp_first));
            chk($sformatf("vec%0d_val_bad", v), 64'(valbad), 64'd0);
            chk($sformatf("vec%0d_other_ch", v), 64'(sidebad), 64'd0);
        end

        // ch1 enabled one cycle after ch0 with phase 3 is equivalent to a
        // same-cycle enable with phase 2: dig1 leads dig0 by two cycles.
        setup(0, 8, 4, 0);
        setup(1, 8, 4, 3);
        cfg_wr(0, ADDR_CTRL, 32'd1);
        cfg_wr(1, ADDR_CTRL, 32'd1);
        @(negedge emu_clk);
        sidebad = 0;
        for (int i = 0; i < 16; i++) begin
            d0 = {d0[14:0], dig[0]};
            d1 = {d1[14:0], dig[1]};
            if (dig[3:2] != 2'b00) sidebad++;
            @(negedge emu_clk);
        end
        chk("phase_dig0", 64'(d0), 64'(16'b1110000111100001));
        chk("phase_dig1", 64'(d1), 64'(16'b1000011110000111));
        chk("phase_others_idle", 64'(sidebad), 64'd0);
        cfg_wr(1, ADDR_CTRL, 32'd0);

        setup(0, 10, 3, 0);
        cfg_wr(0, ADDR_CTRL, 32'd1);
        repeat (4) @(negedge emu_clk);
        cfg_wr(0, ADDR_HIGH, 32'd7);
        sample0(20, d, w);
        chk("shadow_mid_period", d[19:0], 64'(20'b00000011111110001111));

        setup(0, 10, 3, 0);
        cfg_wr(0, ADDR_CTRL, 32'd1);
        repeat (9) @(negedge emu_clk);
        cfg_wr(0, ADDR_HIGH, 32'd7);
        sample0(20, d, w);
        chk("shadow_wrap_cycle", d[19:0], 64'(20'b01110000000111111100));

        setup(0, 6, 2, 0);
        cfg_wr(0, ADDR_CTRL, 32'd3);
        @(negedge emu_clk);
        sample0(20, d, w);
        chk("oneshot_dig", d[19:0], 64'(20'b11000000000000000000));
        chk("oneshot_wrap", w[19:0], 64'(20'b00000100000000000000));
        chk("oneshot_val_low", 64'(val[VAL_W-1:0]), 64'(V_NEG));

        setup(0, 10, 5, 0);
        cfg_wr(0, ADDR_CTRL, 32'd1);
        repeat (3) @(negedge emu_clk);
        chk("pre_reset_dig", 64'(dig[0]), 64'd1);
        emu_rst = 1'b1;
        @(negedge emu_clk);
        emu_rst = 1'b0;
        chk("midrst_dig", 64'(dig), 64'd0);
        chk("midrst_val", 64'(val), 64'd0);
        chk("midrst_wrap", 64'(wrap), 64'd0);
        chk("midrst_ready", 64'(cfg_if.cfg_ready), 64'd0);
        @(negedge emu_clk);
        chk("midrst_ready_back", 64'(cfg_if.cfg_ready), 64'd1);
        cfg_wr(0, ADDR_CTRL, 32'd1);
        valbad = 0;
        for (int i = 0; i < 12; i++) begin
            if (dig[0] !== 1'b0 || val[VAL_W-1:0] !== '0 || wrap[0] !== 1'b0) valbad++;
            @(negedge emu_clk);
        end
        chk("midrst_needs_reprogram", 64'(valbad), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
